// File: rtl/riscv_lsu_mem.sv
// riscv_lsu_mem: handshaked MEM-stage load/store engine with byte enables,
// store-data alignment, load extraction/extension and misalign trapping.
module riscv_lsu_mem #(
    parameter int AddressWidth_dmem = 30,
    parameter int DataWidth = 32,
    parameter int ReadLatency = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [1:0]                   req_size,
    input  logic                         req_unsigned,
    input  logic [31:0]                  req_addr,
    input  logic [DataWidth-1:0]         req_wdata,
    input  logic [4:0]                   req_rd,
    output logic                         stall,
    output logic                         resp_valid,
    output logic                         resp_load,
    output logic                         resp_misalign,
    output logic [DataWidth-1:0]         resp_data,
    output logic [4:0]                   resp_rd,
    output logic [AddressWidth_dmem-1:0] dmem_address0,
    output logic                         dmem_ce0,
    output logic                         dmem_we0,
    output logic [DataWidth/8-1:0]       dmem_be0,
    output logic [DataWidth-1:0]         dmem_d0,
    input  logic [DataWidth-1:0]         dmem_q0
);
    localparam int ByteLanes = DataWidth / 8;
    localparam int OffW = $clog2(ByteLanes);
    localparam int CntW = $clog2(ReadLatency + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsuStateT;

    lsuStateT state, nextState;
    logic weQ, unsQ;
    logic [1:0] sizeQ;
    logic [OffW-1:0] offQ, off;
    logic [4:0] rdQ;
    logic [CntW-1:0] cnt;
    logic misalign, lastWait, accept, loadSign;
    logic [ByteLanes-1:0] sizeMask, be;
    logic [DataWidth-1:0] laneMask, wdataAligned, loadShifted, keepMask, loadExt;

    always_comb begin
        off = req_addr[OffW-1:0];
        misalign = (req_size == 2'd1 & req_addr[0]) | (req_size == 2'd2 & (|req_addr[1:0]))
                 | (req_size == 2'd3 & ((DataWidth == 32) | (|req_addr[2:0])));
        sizeMask = req_size == 2'd0 ? ByteLanes'(8'h01) : req_size == 2'd1 ? ByteLanes'(8'h03)
                 : req_size == 2'd2 ? ByteLanes'(8'h0F) : ByteLanes'(8'hFF);
        be = req_we ? sizeMask << off : '0;
        laneMask = '0;
        for (int i = 0; i < ByteLanes; i++) laneMask[8*i +: 8] = {8{be[i]}};
        wdataAligned = (req_wdata << {off, 3'b000}) & laneMask;
        loadShifted = dmem_q0 >> {offQ, 3'b000};
        // keepMask is all ones for the full-width access, so it is never extended
        keepMask = sizeQ == 2'd0 ? DataWidth'(64'hFF) : sizeQ == 2'd1 ? DataWidth'(64'hFFFF)
                 : sizeQ == 2'd2 ? DataWidth'(64'hFFFF_FFFF) : '1;
        loadSign = ~unsQ & (sizeQ == 2'd0 ? loadShifted[7] : sizeQ == 2'd1 ? loadShifted[15] : loadShifted[31]);
        loadExt = (loadShifted & keepMask) | ({DataWidth{loadSign}} & ~keepMask);
        lastWait = cnt == CntW'(ReadLatency - 1);
        accept = state == IDLE & req_valid;
        req_ready = state == IDLE;
        stall = state == ISSUE | state == WAIT | accept;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = req_valid ? (misalign ? RESP : ISSUE) : IDLE;
            ISSUE:   nextState = weQ ? RESP : WAIT;
            WAIT:    nextState = lastWait ? RESP : WAIT;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            weQ <= 1'b0;
            unsQ <= 1'b0;
            sizeQ <= '0;
            offQ <= '0;
            rdQ <= '0;
            cnt <= '0;
            dmem_ce0 <= 1'b0;
            dmem_we0 <= 1'b0;
            dmem_be0 <= '0;
            dmem_d0 <= '0;
            dmem_address0 <= '0;
            resp_valid <= 1'b0;
            resp_load <= 1'b0;
            resp_misalign <= 1'b0;
            resp_data <= '0;
            resp_rd <= '0;
        end else begin
            dmem_ce0 <= 1'b0;
            dmem_we0 <= 1'b0;
            dmem_be0 <= '0;
            dmem_d0 <= '0;
            dmem_address0 <= '0;
            resp_valid <= 1'b0;
            resp_load <= 1'b0;
            resp_misalign <= 1'b0;
            resp_data <= '0;
            resp_rd <= '0;
            if (accept) begin
                weQ <= req_we;
                unsQ <= req_unsigned;
                sizeQ <= req_size;
                offQ <= off;
                rdQ <= req_rd;
                if (misalign) begin
                    resp_valid <= 1'b1;
                    resp_misalign <= 1'b1;
                    resp_load <= ~req_we;
                    resp_rd <= req_rd;
                end else begin
                    dmem_ce0 <= 1'b1;
                    dmem_we0 <= req_we;
                    dmem_be0 <= be;
                    dmem_d0 <= wdataAligned;
                    dmem_address0 <= AddressWidth_dmem'(req_addr >> OffW);
                end
            end
            if (state == ISSUE) begin
                cnt <= '0;
                if (weQ) begin
                    resp_valid <= 1'b1;
                    resp_rd <= rdQ;
                end
            end
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (lastWait) begin
                    resp_valid <= 1'b1;
                    resp_load <= 1'b1;
                    resp_data <= loadExt;
                    resp_rd <= rdQ;
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_lsu_mem.sv
// tb_riscv_lsu_mem: scoreboard bench driving a 32-bit/ReadLatency=2 and a
// 64-bit/ReadLatency=1 instance, each backed by its own dmem model.
module tb_riscv_lsu_mem;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic we = 1'b0, uns = 1'b0, v32 = 1'b0, v64 = 1'b0;
    logic [1:0] size = '0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [4:0] rd = '0;

    logic rdy32, st32, rv32, rl32, rm32, ce32, we32o;
    logic [31:0] rdat32, d32, q32, r32a, bm32;
    logic [4:0] rrd32;
    logic [29:0] a32;
    logic [3:0] be32;
    logic rdy64, st64, rv64, rl64, rm64, ce64, we64o;
    logic [63:0] rdat64, d64, q64, bm64;
    logic [4:0] rrd64;
    logic [29:0] a64;
    logic [7:0] be64;

    riscv_lsu_mem #(.AddressWidth_dmem(30), .DataWidth(32), .ReadLatency(2)) u32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_we(we), .req_size(size),
        .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata[31:0]), .req_rd(rd), .stall(st32),
        .resp_valid(rv32), .resp_load(rl32), .resp_misalign(rm32), .resp_data(rdat32), .resp_rd(rrd32),
        .dmem_address0(a32), .dmem_ce0(ce32), .dmem_we0(we32o), .dmem_be0(be32), .dmem_d0(d32), .dmem_q0(q32)
    );
    riscv_lsu_mem #(.AddressWidth_dmem(30), .DataWidth(64), .ReadLatency(1)) u64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64), .req_we(we), .req_size(size),
        .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata), .req_rd(rd), .stall(st64),
        .resp_valid(rv64), .resp_load(rl64), .resp_misalign(rm64), .resp_data(rdat64), .resp_rd(rrd64),
        .dmem_address0(a64), .dmem_ce0(ce64), .dmem_we0(we64o), .dmem_be0(be64), .dmem_d0(d64), .dmem_q0(q64)
    );

    function automatic logic [63:0] lanes(input logic [7:0] b);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{b[i]}};
        return m;
    endfunction

    // dmem models: write on the ce cycle, read data valid ReadLatency cycles later
    logic [31:0] mem32 [4096];
    logic [63:0] mem64 [4096];
    assign bm32 = 32'(lanes({4'b0, be32}));
    assign bm64 = lanes(be64);
    always @(posedge clk) begin
        if (ce32 && we32o) mem32[a32[11:0]] <= (mem32[a32[11:0]] & ~bm32) | (d32 & bm32);
        r32a <= mem32[a32[11:0]];
        q32 <= r32a;
        if (ce64 && we64o) mem64[a64[11:0]] <= (mem64[a64[11:0]] & ~bm64) | (d64 & bm64);
        q64 <= mem64[a64[11:0]];
    end

    logic [31:0] sh32 [4096];
    logic [63:0] sh64 [4096];

    typedef struct packed {
        logic load;
        logic mis;
        logic [63:0] data;
        logic [4:0] rd;
        logic [31:0] cyc;
    } sbT;
    sbT q32s[$], q64s[$];
    sbT m32, m64;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic predict(input bit is64, input logic w, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [63:0] wd, input logic [4:0] r, output sbT e);
        int nb, ln, off, idx;
        logic [63:0] v, d;
        nb = 1 << s;
        ln = is64 ? 8 : 4;
        off = int'(a % ln);
        idx = int'((a / ln) % 4096);
        e = '0;
        e.rd = r;
        e.load = !w;
        e.mis = ((a & (nb - 1)) != 0) || (s == 2'd3 && !is64);
        if (e.mis) e.cyc = cyc + 1;
        else if (w) begin
            e.cyc = cyc + 2;
            for (int k = 0; k < nb; k++)
                if (is64) sh64[idx][8*(off+k) +: 8] = wd[8*k +: 8];
                else sh32[idx][8*(off+k) +: 8] = wd[8*k +: 8];
        end else begin
            e.cyc = cyc + (is64 ? 3 : 4);
            v = (is64 ? sh64[idx] : {32'b0, sh32[idx]}) >> (8 * off);
            case (s)
                2'd0: d = u ? {56'b0, v[7:0]} : {{56{v[7]}}, v[7:0]};
                2'd1: d = u ? {48'b0, v[15:0]} : {{48{v[15]}}, v[15:0]};
                2'd2: d = u ? {32'b0, v[31:0]} : {{32{v[31]}}, v[31:0]};
                default: d = v;
            endcase
            e.data = is64 ? d : {32'b0, d[31:0]};
        end
    endtask

    task automatic issue(input bit is64, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [63:0] wd, input logic [4:0] r);
        sbT e;
        @(negedge clk);
        we = w; size = s; uns = u; addr = a; wdata = wd; rd = r;
        predict(is64, w, s, u, a, wd, r, e);
        if (is64) begin q64s.push_back(e); v64 = 1'b1; end
        else begin q32s.push_back(e); v32 = 1'b1; end
        #1;
        check("ready", is64 ? rdy64 : rdy32, 1);
        check("stallT", is64 ? st64 : st32, 1);
        @(negedge clk);
        v32 = 1'b0; v64 = 1'b0;
        #1;
        check("stallT1", is64 ? st64 : st32, !e.mis);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32s.size() + q64s.size()) != 0 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drainTimeout", q32s.size() + q64s.size(), 0);
        q32s.delete();
        q64s.delete();
    endtask

    always @(negedge clk) begin
        if (rv32) begin
            if (q32s.size() == 0) check("unexp32", 1, 0);
            else begin
                m32 = q32s.pop_front();
                check("data32", rdat32, m32.data);
                check("mis32", rm32, m32.mis);
                check("load32", rl32, m32.load);
                check("rd32", rrd32, m32.rd);
                check("cyc32", cyc, m32.cyc);
                check("stallR32", st32, 0);
            end
        end else check("rzero32", {rl32, rm32, rdat32, rrd32}, 0);
        if (!ce32) check("dzero32", {we32o, be32, d32, a32}, 0);
        if (rv64) begin
            if (q64s.size() == 0) check("unexp64", 1, 0);
            else begin
                m64 = q64s.pop_front();
                check("data64", rdat64, m64.data);
                check("mis64", rm64, m64.mis);
                check("load64", rl64, m64.load);
                check("rd64", rrd64, m64.rd);
                check("cyc64", cyc, m64.cyc);
                check("stallR64", st64, 0);
            end
        end else check("rzero64", {rl64, rm64, rdat64, rrd64}, 0);
        if (!ce64) check("dzero64", {we64o, be64, d64, a64}, 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int tS, tL;
        repeat (3) @(negedge clk);
        check("rstOut", {rv32, ce32, rv64, ce64}, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("idleRdy", {rdy32, rdy64, st32, st64}, 4'b1100);

        issue(0, 1, 0, 0, 32'h1003, 64'hAB, 5'd1);
        check("sbCe", ce32, 1);
        check("sbWe", we32o, 1);
        check("sbBe", be32, 4'b1000);
        check("sbD", d32, 32'hAB00_0000);
        check("sbAddr", a32, 30'h400);
        drain();
        issue(0, 0, 0, 0, 32'h1003, 0, 5'd2);
        drain();
        issue(0, 1, 2, 0, 32'h2000, 64'h8001_1234, 5'd3);
        drain();
        issue(0, 0, 1, 0, 32'h2002, 0, 5'd4);
        drain();
        issue(0, 0, 1, 1, 32'h2002, 0, 5'd5);
        drain();
        issue(0, 0, 0, 0, 32'h2003, 0, 5'd6);
        drain();
        issue(0, 0, 0, 1, 32'h2001, 0, 5'd7);
        drain();
        issue(0, 0, 2, 0, 32'h2000, 0, 5'd8);
        drain();
        issue(0, 0, 2, 0, 32'h0006, 0, 5'd9);
        check("misNoCe", ce32, 0);
        drain();
        issue(0, 1, 1, 0, 32'h2001, 64'hFFFF, 5'd10);
        drain();
        issue(0, 0, 3, 0, 32'h2000, 0, 5'd11);
        drain();

        issue(0, 0, 2, 0, 32'h2000, 0, 5'd12);
        @(negedge clk);
        rst = 1'b0;
        q32s.delete();
        @(negedge clk);
        #1;
        check("rstRv", rv32, 0);
        check("rstStall", st32, 0);
        check("rstCe", ce32, 0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("rstRdy", rdy32, 1);

        issue(1, 1, 3, 0, 32'h10, 64'h0123_4567_89AB_CDEF, 5'd13);
        drain();
        issue(1, 0, 3, 0, 32'h10, 0, 5'd14);
        drain();
        issue(1, 0, 2, 0, 32'h14, 0, 5'd15);
        drain();
        issue(1, 0, 2, 0, 32'h10, 0, 5'd16);
        drain();
        issue(1, 0, 2, 1, 32'h10, 0, 5'd17);
        drain();
        issue(1, 0, 3, 0, 32'h14, 0, 5'd18);
        drain();
        issue(1, 1, 0, 0, 32'h17, 64'h55, 5'd19);
        drain();
        issue(1, 0, 0, 1, 32'h17, 0, 5'd20);
        drain();

        issue(1, 1, 2, 0, 32'h20, 64'hDEAD_BEEF, 5'd21);
        tS = cyc - 1;
        drain();
        issue(1, 0, 2, 0, 32'h20, 0, 5'd22);
        tL = cyc - 1;
        check("b2bAccept", tL - tS, 3);
        drain();

        for (int i = 0; i < 4; i++) begin
            issue(0, 1, 2, 0, 32'h3000 + 4 * i, {32'b0, $urandom}, 5'(i));
            drain();
        end
        for (int i = 0; i < 2; i++) begin
            issue(1, 1, 3, 0, 32'h3000 + 8 * i, {$urandom, $urandom}, 5'(i));
            drain();
        end
        for (int i = 0; i < 48; i++) begin
            issue(i[0], 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  32'h3000 + $urandom_range(0, 15), {$urandom, $urandom}, 5'(i));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
